// File: rtl/ufp_if.sv
// Unsigned fixed-point sample: WL = IW integer bits + QW fraction bits.
interface ufp_if #(
  parameter int IW = 8,
  parameter int QW = 8
);
  localparam int WL = IW + QW;

  logic [WL-1:0] val;

  // Producer side drives the sample, consumer side reads it.
  modport master (output val);
  modport slave  (input  val);
  // Consumer view used by converters.
  modport in     (input  val);
endinterface

// File: rtl/ufp_to_float.sv
// Iterative unsigned fixed-point to IEEE-754 float converter.
// Normalizes one bit per cycle, then rounds to nearest, ties to even.
// Output has sign 0, no subnormals, infinities or NaNs.
module ufp_to_float #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  ufp_if.in              fp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] out_bits,
  output logic           out_inexact
);

  localparam int WL   = $bits(fp.val);
  localparam int QW   = fp.QW;
  localparam int BIAS = (2 ** (EW - 1)) - 1;
  localparam int SW   = MW + 1;                     // significand incl. hidden bit
  localparam int XW   = (WL > SW + 2) ? WL : SW + 2; // room for sig, guard, sticky
  localparam int LZW  = $clog2(WL + 1);
  localparam int EXP_TOP = WL - 1 - QW + BIAS;      // biased exponent when lz == 0

  // Exponent range must fit the normal float range for every input.
  if (WL - 1 - QW + BIAS > (2 ** EW) - 2) begin : g_chk_ovf
    $error("ufp_to_float: exponent overflow possible for this WL/QW/EW");
  end
  if (BIAS - QW < 1) begin : g_chk_sub
    $error("ufp_to_float: subnormal results possible for this QW/EW");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [WL-1:0]  sreg_q, sreg_d;
  logic [LZW-1:0] lz_q, lz_d;
  logic [EW+MW:0] bits_q, bits_d;
  logic           inexact_q, inexact_d;

  logic [XW-1:0]  ext;
  logic [SW-1:0]  sig;
  logic           guard;
  logic           sticky;
  logic           inc;
  logic           carry;
  logic [MW-1:0]  frac_v;
  logic [EW-1:0]  exp_v;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign out_bits    = bits_q;
  assign out_inexact = inexact_q;

  // Rounding datapath: left-align the normalized register so that short
  // words get zero padding and guard/sticky always exist.
  always_comb begin
    ext    = XW'(sreg_q) << (XW - WL);
    sig    = ext[XW-1 -: SW];
    guard  = ext[XW-1-SW];
    sticky = |ext[XW-2-SW:0];
    inc    = guard && (sticky || sig[0]);
    // An all-ones significand rolls over to 1.000... and bumps the exponent.
    carry  = inc && (&sig);
    frac_v = sig[MW-1:0] + MW'(inc);
    exp_v  = EW'(EXP_TOP) - EW'(lz_q) + EW'(carry);
  end

  // Next-state and result logic for the conversion FSM.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    lz_d      = lz_q;
    bits_d    = bits_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d = fp.val;
          lz_d   = '0;
          // Zero skips normalization; ROUND emits the all-zero pattern.
          state_d = (fp.val == '0) ? ROUND : NORM;
        end
      end
      NORM: begin
        if (sreg_q[WL-1]) begin
          state_d = ROUND;
        end else begin
          sreg_d = sreg_q << 1;
          lz_d   = lz_q + LZW'(1);
        end
      end
      ROUND: begin
        // A nonzero value is always normalized here, so zero means zero input.
        if (sreg_q == '0) begin
          bits_d    = '0;
          inexact_d = 1'b0;
        end else begin
          bits_d    = {1'b0, exp_v, frac_v};
          inexact_d = guard || sticky;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      lz_q      <= '0;
      bits_q    <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      lz_q      <= lz_d;
      bits_q    <= bits_d;
      inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_ufp_to_float.sv
// Directed bench for ufp_to_float in three formats: Q8.8, Q32.0 and Q12.12.
module tb_ufp_to_float;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Q8.8 instance
  ufp_if #(.IW(8), .QW(8)) if16 ();
  logic iv16, ir16, ov16, or16, oi16;
  logic [31:0] ob16;
  ufp_to_float #(.EW(8), .MW(23)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .fp(if16),
    .out_valid(ov16), .out_ready(or16), .out_bits(ob16), .out_inexact(oi16)
  );

  // Q32.0 instance
  ufp_if #(.IW(32), .QW(0)) if32 ();
  logic iv32, ir32, ov32, or32, oi32;
  logic [31:0] ob32;
  ufp_to_float #(.EW(8), .MW(23)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .fp(if32),
    .out_valid(ov32), .out_ready(or32), .out_bits(ob32), .out_inexact(oi32)
  );

  // Q12.12 instance
  ufp_if #(.IW(12), .QW(12)) if24 ();
  logic iv24, ir24, ov24, or24, oi24;
  logic [31:0] ob24;
  ufp_to_float #(.EW(8), .MW(23)) u24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .fp(if24),
    .out_valid(ov24), .out_ready(or24), .out_bits(ob24), .out_inexact(oi24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      0: begin iv16 = v; if16.val = d[15:0]; end
      1: begin iv32 = v; if32.val = d;       end
      default: begin iv24 = v; if24.val = d[23:0]; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input logic v);
    case (sel)
      0: or16 = v;
      1: or32 = v;
      default: or24 = v;
    endcase
  endtask

  function automatic logic g_ov(input int sel);
    case (sel)
      0: return ov16;
      1: return ov32;
      default: return ov24;
    endcase
  endfunction

  function automatic logic g_ir(input int sel);
    case (sel)
      0: return ir16;
      1: return ir32;
      default: return ir24;
    endcase
  endfunction

  function automatic logic [31:0] g_ob(input int sel);
    case (sel)
      0: return ob16;
      1: return ob32;
      default: return ob24;
    endcase
  endfunction

  function automatic logic g_oi(input int sel);
    case (sel)
      0: return oi16;
      1: return oi32;
      default: return oi24;
    endcase
  endfunction

  // Reference for Q12.12: every 24-bit value is exact in binary32, so the
  // double encoding can be repacked directly.
  function automatic logic [31:0] ref24(input logic [23:0] v);
    real r;
    logic [63:0] d;
    logic [7:0] e;
    if (v == '0) return 32'h0;
    r = real'(v) / 4096.0;
    d = $realtobits(r);
    e = 8'(int'(d[62:52]) - 1023 + 127);
    return {1'b0, e, d[51:29]};
  endfunction

  // One conversion. Called #1 after a posedge. elat < 0 skips the latency
  // check; hold > 0 applies backpressure and pokes in_valid meanwhile.
  task automatic conv(input int sel, input logic [31:0] v, input logic [31:0] eb,
                      input logic ei, input int elat, input int hold, input string tag);
    int lat;
    bit got;
    chk({tag, ".in_ready"}, 32'(g_ir(sel)), 32'd1);
    drive(sel, 1'b1, v);
    @(posedge clk); #1;                    // capture edge = cycle 0
    drive(sel, 1'b0, 32'h0);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (i > 1 || !g_ov(sel)) begin
        @(posedge clk); #1;
      end
      if (g_ov(sel)) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({tag, ".done"}, 32'(got), 32'd1);
    if (elat >= 0) chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".bits"}, g_ob(sel), eb);
    chk({tag, ".inexact"}, 32'(g_oi(sel)), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      drive(sel, 1'b1, 32'h0000_1234);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(g_ov(sel)), 32'd1);
      chk({tag, ".hold_bits"}, g_ob(sel), eb);
      chk({tag, ".hold_ready"}, 32'(g_ir(sel)), 32'd0);
    end
    drive(sel, 1'b0, 32'h0);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    chk({tag, ".release_valid"}, 32'(g_ov(sel)), 32'd0);
    chk({tag, ".release_ready"}, 32'(g_ir(sel)), 32'd1);
  endtask

  initial begin
    logic [23:0] rv;
    rst = 1'b1;
    iv16 = 1'b0; iv32 = 1'b0; iv24 = 1'b0;
    or16 = 1'b0; or32 = 1'b0; or24 = 1'b0;
    if16.val = '0; if32.val = '0; if24.val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(ov16), 32'd0);
    chk("rst.out_bits", ob16, 32'h0);
    chk("rst.inexact", 32'(oi16), 32'd0);
    chk("rst.in_ready", 32'(ir16), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.released_ready", 32'(ir16), 32'd1);

    // Q8.8 vectors
    conv(0, 32'h0100, 32'h3F80_0000, 1'b0, 9,  0, "q8_one");
    conv(0, 32'h0001, 32'h3B80_0000, 1'b0, 17, 0, "q8_lsb");
    conv(0, 32'hFFFF, 32'h437F_FF00, 1'b0, 2,  0, "q8_max");

    // Q32.0 rounding cases
    conv(1, 32'h0100_0001, 32'h4B80_0000, 1'b1, 9, 0, "q32_tie_down");
    conv(1, 32'h0100_0003, 32'h4B80_0002, 1'b1, 9, 0, "q32_tie_up");
    conv(1, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 2, 0, "q32_carry");

    // Zero with 10 cycles of backpressure, then the next sample goes through
    conv(0, 32'h0000, 32'h0000_0000, 1'b0, 1, 10, "q8_zero_bp");
    conv(0, 32'h0100, 32'h3F80_0000, 1'b0, 9, 0, "q8_after_bp");

    // Reset during normalization of 0x0001
    drive(0, 1'b1, 32'h0001);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.busy", 32'(ir16), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.out_valid", 32'(ov16), 32'd0);
    chk("midrst.out_bits", ob16, 32'h0);
    chk("midrst.in_ready_in_rst", 32'(ir16), 32'd0);
    rst = 1'b0;
    #1;
    conv(0, 32'h0100, 32'h3F80_0000, 1'b0, 9, 0, "midrst.next");

    // Random Q12.12 inputs, always exact
    for (int k = 0; k < 1000; k++) begin
      rv = 24'($urandom_range(0, 32'h00FF_FFFF));
      conv(2, 32'(rv), ref24(rv), 1'b0, -1, 0, $sformatf("q12_rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
